// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: horizontal/vertical counters, registered
// sync/blank/position decodes aligned to the counters, clock enable, restart, frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0,
    parameter int FRAME_W    = 8,
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW        = $clog2(H_TOTAL),
    localparam int VW        = $clog2(V_TOTAL)
) (
    input  logic               pixelClk,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    output logic [HW-1:0]      hCount,
    output logic [VW-1:0]      vCount,
    output logic               hSync,
    output logic               vSync,
    output logic               videoActive,
    output logic               endOfLine,
    output logic               endOfFrame,
    output logic               frameStart,
    output logic [FRAME_W-1:0] frameCount
);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_param_check
        $error("vga_timing_gen: active, porch and sync parameters must all be non-zero");
    end

    // Every boundary is strictly below the total, so it fits in the counter width.
    localparam logic [HW-1:0] H_LAST       = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST       = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_END    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          H_ASSERT     = (H_SYNC_POL != 0);
    localparam logic          V_ASSERT     = (V_SYNC_POL != 0);

    logic [HW-1:0]      h_next;
    logic [VW-1:0]      v_next;
    logic [FRAME_W-1:0] frame_next;
    logic               h_wrap;
    logic               v_wrap;
    logic               hsync_next;
    logic               vsync_next;
    logic               active_next;
    logic               eol_next;
    logic               eof_next;
    logic               start_next;

    always_comb begin
        h_wrap     = (hCount == H_LAST);
        v_wrap     = (vCount == V_LAST);
        h_next     = hCount;
        v_next     = vCount;
        frame_next = frameCount;
        if (restart) begin
            h_next = '0;
            v_next = '0;
        end else if (en) begin
            h_next = h_wrap ? '0 : hCount + 1'b1;
            if (h_wrap) begin
                v_next = v_wrap ? '0 : vCount + 1'b1;
            end
            if (h_wrap && v_wrap) begin
                frame_next = frameCount + 1'b1;
            end
        end
    end

    // Decode the next counter values so the registered flags line up with the counters.
    always_comb begin
        hsync_next  = ((h_next >= H_SYNC_START) && (h_next < H_SYNC_END)) ? H_ASSERT : ~H_ASSERT;
        vsync_next  = ((v_next >= V_SYNC_START) && (v_next < V_SYNC_END)) ? V_ASSERT : ~V_ASSERT;
        active_next = (h_next < H_ACT_END) && (v_next < V_ACT_END);
        eol_next    = (h_next == H_LAST);
        eof_next    = (h_next == H_LAST) && (v_next == V_LAST);
        start_next  = (h_next == '0) && (v_next == '0);
    end

    always_ff @(posedge pixelClk or posedge rst) begin
        if (rst) begin
            hCount      <= '0;
            vCount      <= '0;
            frameCount  <= '0;
            hSync       <= ~H_ASSERT;
            vSync       <= ~V_ASSERT;
            videoActive <= 1'b1;
            endOfLine   <= 1'b0;
            endOfFrame  <= 1'b0;
            frameStart  <= 1'b1;
        end else begin
            hCount      <= h_next;
            vCount      <= v_next;
            frameCount  <= frame_next;
            hSync       <= hsync_next;
            vSync       <= vsync_next;
            videoActive <= active_next;
            endOfLine   <= eol_next;
            endOfFrame  <= eof_next;
            frameStart  <= start_next;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny 16x7 instance, both checked
// against a position-index reference model, with constant tables for the key boundaries.
module tb_vga_timing_gen;

    logic pixelClk = 1'b0;
    logic rst      = 1'b1;
    logic en       = 1'b1;
    logic restart  = 1'b0;

    always #5 pixelClk = ~pixelClk;

    // Default-parameter instance
    logic [9:0] d_h, d_v;
    logic       d_hs, d_vs, d_va, d_eol, d_eof, d_fs;
    logic [7:0] d_fc;

    vga_timing_gen dut_d (
        .pixelClk(pixelClk), .rst(rst), .en(en), .restart(restart),
        .hCount(d_h), .vCount(d_v), .hSync(d_hs), .vSync(d_vs),
        .videoActive(d_va), .endOfLine(d_eol), .endOfFrame(d_eof),
        .frameStart(d_fs), .frameCount(d_fc)
    );

    // Small instance: H_TOTAL=16, V_TOTAL=7, positive hSync
    logic [3:0] s_h;
    logic [2:0] s_v;
    logic       s_hs, s_vs, s_va, s_eol, s_eof, s_fs;
    logic [7:0] s_fc;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_SYNC_POL(1), .V_SYNC_POL(0), .FRAME_W(8)
    ) dut_s (
        .pixelClk(pixelClk), .rst(rst), .en(en), .restart(restart),
        .hCount(s_h), .vCount(s_v), .hSync(s_hs), .vSync(s_vs),
        .videoActive(s_va), .endOfLine(s_eol), .endOfFrame(s_eof),
        .frameStart(s_fs), .frameCount(s_fc)
    );

    localparam int D_LEN = 800 * 525;
    localparam int S_LEN = 16 * 7;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        va;
        logic        eol;
        logic        eof;
        logic        fs;
        logic [7:0]  fc;
    } obs_t;

    typedef struct {
        int   adv;
        obs_t exp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Model state: enabled-cycle index within the frame, and completed frames.
    int t_d = 0, fc_d = 0, t_s = 0, fc_s = 0;

    function automatic obs_t ref_out(int t, int fc, int ha, int hfp, int hsw, int hbp,
                                     int va, int vfp, int vsw, int vbp, bit hpol, bit vpol);
        obs_t r;
        int ht = ha + hfp + hsw + hbp;
        int vt = va + vfp + vsw + vbp;
        int h  = t % ht;
        int v  = t / ht;
        r.h   = 16'(h);
        r.v   = 16'(v);
        r.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : !hpol;
        r.vs  = (v >= va + vfp && v < va + vfp + vsw) ? vpol : !vpol;
        r.va  = (h < ha) && (v < va);
        r.eol = (h == ht - 1);
        r.eof = (h == ht - 1) && (v == vt - 1);
        r.fs  = (t == 0);
        r.fc  = 8'(fc);
        return r;
    endfunction

    function automatic obs_t get_d();
        return '{h: 16'(d_h), v: 16'(d_v), hs: d_hs, vs: d_vs, va: d_va,
                 eol: d_eol, eof: d_eof, fs: d_fs, fc: d_fc};
    endfunction

    function automatic obs_t get_s();
        return '{h: 16'(s_h), v: 16'(s_v), hs: s_hs, vs: s_vs, va: s_va,
                 eol: s_eol, eof: s_eof, fs: s_fs, fc: s_fc};
    endfunction

    task automatic compare(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got h=%0d v=%0d hs=%b vs=%b va=%b eol=%b eof=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b va=%b eol=%b eof=%b fs=%b fc=%0d",
                     name, got.h, got.v, got.hs, got.vs, got.va, got.eol, got.eof, got.fs, got.fc,
                     exp.h, exp.v, exp.hs, exp.vs, exp.va, exp.eol, exp.eof, exp.fs, exp.fc);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic check_both(input string name);
        compare({name, " dflt"}, get_d(), ref_out(t_d, fc_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
        compare({name, " small"}, get_s(), ref_out(t_s, fc_s, 8, 2, 3, 3, 4, 1, 1, 1, 1'b1, 1'b0));
    endtask

    task automatic adv(inout int t, inout int fc, input int len);
        if (restart) begin
            t = 0;
        end else if (en) begin
            t++;
            if (t == len) begin
                t  = 0;
                fc = (fc + 1) % 256;
            end
        end
    endtask

    task automatic tick();
        @(posedge pixelClk);
        if (rst) begin
            t_d = 0; fc_d = 0; t_s = 0; fc_s = 0;
        end else begin
            adv(t_d, fc_d, D_LEN);
            adv(t_s, fc_s, S_LEN);
        end
        #1;
    endtask

    task automatic run_checked(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            tick();
            check_both(name);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    vec_t tbl[10];

    task automatic set_vec(input int i, input int a, input int h, input int v,
                           input bit hs, input bit va, input bit eol, input bit fs);
        tbl[i].adv = a;
        tbl[i].exp = '{h: 16'(h), v: 16'(v), hs: hs, vs: 1'b1, va: va,
                       eol: eol, eof: 1'b0, fs: fs, fc: 8'd0};
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default-instance line boundaries, cumulative advances from (0,0)
        set_vec(0,   0,   0, 0, 1, 1, 0, 1);
        set_vec(1,   1,   1, 0, 1, 1, 0, 0);
        set_vec(2, 638, 639, 0, 1, 1, 0, 0);
        set_vec(3,   1, 640, 0, 1, 0, 0, 0);
        set_vec(4,  15, 655, 0, 1, 0, 0, 0);
        set_vec(5,   1, 656, 0, 0, 0, 0, 0);
        set_vec(6,  95, 751, 0, 0, 0, 0, 0);
        set_vec(7,   1, 752, 0, 1, 0, 0, 0);
        set_vec(8,  47, 799, 0, 1, 0, 1, 0);
        set_vec(9,   1,   0, 1, 1, 1, 0, 0);

        repeat (3) tick();
        check_both("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            repeat (tbl[i].adv) tick();
            compare($sformatf("tbl%0d", i), get_d(), tbl[i].exp);
            check_both($sformatf("tbl%0d model", i));
            $display("vec %0d: h=%0d v=%0d hSync=%b active=%b eol=%b fs=%b",
                     i, d_h, d_v, d_hs, d_va, d_eol, d_fs);
        end

        // Asynchronous reset in mid-cycle at (700,1)
        repeat (700) tick();
        check_eq("pre-rst hCount", int'(d_h), 700);
        #3;
        rst = 1'b1;
        t_d = 0; fc_d = 0; t_s = 0; fc_s = 0;
        #1;
        check_both("async rst");
        check_eq("async rst hCount", int'(d_h), 0);
        check_eq("async rst videoActive", int'(d_va), 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("post-rst hCount", int'(d_h), 1);
        check_eq("post-rst vCount", int'(d_v), 0);

        // Enable one cycle in three
        for (int i = 0; i < 300; i++) begin
            en = (i % 3 == 0);
            tick();
            check_both("en 1of3");
        end
        en = 1'b1;
        check_eq("en 1of3 hCount", int'(d_h), 101);

        // Restart at (5,3) with frameCount=5 on the small instance
        reset_pulse();
        run_checked(5 * S_LEN + 3 * 16 + 5, "to restart");
        check_eq("pre-restart s_fc", int'(s_fc), 5);
        check_eq("pre-restart s_v", int'(s_v), 3);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_both("restart mid");
        check_eq("restart s_h", int'(s_h), 0);
        check_eq("restart s_fs", int'(s_fs), 1);
        check_eq("restart s_fc", int'(s_fc), 5);

        // Restart on the last pixel must not count a frame
        run_checked(S_LEN - 1, "to last");
        check_eq("last s_eof", int'(s_eof), 1);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        check_both("restart last");
        check_eq("restart last s_fc", int'(s_fc), 5);
        check_eq("restart last s_v", int'(s_v), 0);

        // Restart while disabled
        run_checked(20, "pre en0");
        en = 1'b0;
        restart = 1'b1;
        tick();
        check_eq("restart en0 s_h", int'(s_h), 0);
        check_eq("restart en0 d_h", int'(d_h), 0);
        en = 1'b1;
        restart = 1'b0;
        tick();
        check_eq("after restart en0 s_h", int'(s_h), 1);

        // Natural end of frame
        run_checked(S_LEN - 2, "to eof");
        check_eq("eof s_eof", int'(s_eof), 1);
        tick();
        check_eq("new frame s_fc", int'(s_fc), 6);
        check_eq("new frame s_fs", int'(s_fs), 1);

        // frameCount wrap after 256 frames
        reset_pulse();
        run_checked(255 * S_LEN, "frames");
        check_eq("255 frames s_fc", int'(s_fc), 255);
        run_checked(S_LEN, "wrap");
        check_eq("wrap s_fc", int'(s_fc), 0);
        check_eq("wrap s_fs", int'(s_fs), 1);

        // Random enable and occasional restart
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            restart = ($urandom_range(0, 199) == 0);
            tick();
            check_both("random");
        end
        en = 1'b1;
        restart = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
